config_chain_loader: RTL and testbench

Sequencer that loads a configuration shift chain from a word-wide source. It accepts configuration words over a valid/ready handshake, serialises them LSB-first, and drives the chain's shift_enable/shift_in until exactly CHAIN_LENGTH bits have been shifted. It then pulses done. It sits between the config bus/host interface and one shift chain instance, and is the only driver of that chain's shift controls.

---
 rtl/config_chain_loader_if.sv | 37 +++
 rtl/config_chain_loader.sv | 91 +++++++++
 tb/tb_config_chain_loader.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/config_chain_loader_if.sv
// ============================================================================
// Module      : config_chain_loader_if
// Description : Control and word-stream bundle between a configuration host
//               and config_chain_loader, plus the chain shift controls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface config_chain_loader_if #(
  parameter int CHAIN_LENGTH = 64,
  parameter int WORD_WIDTH   = 8
);
  logic                              start;
  logic                              abort;
  logic                              word_valid;
  logic [WORD_WIDTH-1:0]             word_data;
  logic                              word_ready;
  logic                              chain_shift_enable;
  logic                              chain_shift_in;
  logic                              busy;
  logic                              done;
  logic [$clog2(CHAIN_LENGTH+1)-1:0] bits_remaining;

  modport master (
    output start, abort, word_valid, word_data,
    input  word_ready, chain_shift_enable, chain_shift_in, busy, done,
           bits_remaining
  );

  modport slave (
    input  start, abort, word_valid, word_data,
    output word_ready, chain_shift_enable, chain_shift_in, busy, done,
           bits_remaining
  );
endinterface

`default_nettype wire

// File: rtl/config_chain_loader.sv
// ============================================================================
// Module      : config_chain_loader
// Description : Accepts config words and serialises them LSB-first into a
//               shift chain until CHAIN_LENGTH bits are shifted, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module config_chain_loader #(
  parameter int CHAIN_LENGTH = 64,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  config_chain_loader_if.slave  bus
);

  localparam int c_CNT_W = $clog2(CHAIN_LENGTH + 1);

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_WAIT_WORD = 2'd1;
  localparam logic [1:0] c_SHIFT     = 2'd2;
  localparam logic [1:0] c_DONE      = 2'd3;

  logic [1:0]            r_state;
  logic [WORD_WIDTH-1:0] r_shreg;
  logic [c_CNT_W-1:0]    r_bits;
  logic [c_CNT_W-1:0]    r_word_cnt;
  logic [c_CNT_W-1:0]    w_take;

  // Bits taken from the next word: never more than remain in the chain,
  // so the final word of an uneven chain has its upper bits discarded.
  assign w_take = (32'(r_bits) >= WORD_WIDTH) ? c_CNT_W'(WORD_WIDTH) : r_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_shreg    <= '0;
      r_bits     <= '0;
      r_word_cnt <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.start) begin
            r_state <= c_WAIT_WORD;
            r_bits  <= c_CNT_W'(CHAIN_LENGTH);
          end
        end
        c_WAIT_WORD: begin
          if (bus.abort) begin
            r_state <= c_IDLE;
            r_bits  <= '0;
          end else if (bus.word_valid) begin
            r_shreg    <= bus.word_data;
            r_word_cnt <= w_take;
            r_state    <= c_SHIFT;
          end
        end
        c_SHIFT: begin
          r_shreg    <= r_shreg >> 1;
          r_word_cnt <= r_word_cnt - c_CNT_W'(1);
          if (bus.abort) begin
            r_state <= c_IDLE;
            r_bits  <= '0;
          end else begin
            r_bits <= r_bits - c_CNT_W'(1);
            if (r_word_cnt == c_CNT_W'(1)) begin
              r_state <= (r_bits == c_CNT_W'(1)) ? c_DONE : c_WAIT_WORD;
            end
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign bus.word_ready         = (r_state == c_WAIT_WORD);
  assign bus.chain_shift_enable = (r_state == c_SHIFT);
  assign bus.chain_shift_in     = (r_state == c_SHIFT) && r_shreg[0];
  assign bus.busy               = (r_state == c_WAIT_WORD) || (r_state == c_SHIFT);
  assign bus.done               = (r_state == c_DONE);
  assign bus.bits_remaining     = r_bits;

endmodule

`default_nettype wire

// File: tb/tb_config_chain_loader.sv
// ============================================================================
// Module      : tb_config_chain_loader
// Description : Directed self-checking bench for config_chain_loader with a
//               scoreboard of expected shifted bits and a model of the chain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_config_chain_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  config_chain_loader_if #(.CHAIN_LENGTH(12), .WORD_WIDTH(8)) s ();
  config_chain_loader_if #(.CHAIN_LENGTH(1),  .WORD_WIDTH(8)) t ();

  config_chain_loader #(.CHAIN_LENGTH(12), .WORD_WIDTH(8)) u_dut12 (
    .clk (clk),
    .rst (rst),
    .bus (s)
  );

  config_chain_loader #(.CHAIN_LENGTH(1), .WORD_WIDTH(8)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (t)
  );

  int         checks = 0;
  int         errors = 0;
  bit         q[$];
  logic [11:0] chain     = '0;
  logic [11:0] exp_chain = '0;
  int         shifts, hs, cyc, last_shift_cyc, dones;
  bit         last_hs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; monitors the 12-bit instance and pops the scoreboard per shift.
  task automatic tick();
    last_hs = s.word_ready && s.word_valid;
    if (last_hs) hs++;
    @(posedge clk);
    #1;
    cyc++;
    if (s.chain_shift_enable) begin
      shifts++;
      last_shift_cyc = cyc;
      chain = {chain[10:0], s.chain_shift_in};
      chk("sb_has_entry", 32'(q.size() > 0), 1);
      if (q.size() > 0) chk("shift_in", 32'(s.chain_shift_in), 32'(q.pop_front()));
    end
    if (s.done) dones++;
  endtask

  task automatic push_word(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      q.push_back(w[i]);
      exp_chain = {exp_chain[10:0], w[i]};
    end
  endtask

  task automatic wait_hs();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (last_hs) break;
    end
    chk("hs_timeout", 32'(last_hs), 1);
  endtask

  task automatic load12(input logic [7:0] w0, input logic [7:0] w1,
                        input bit stall, input bit poke);
    q.delete();
    shifts = 0; hs = 0; dones = 0; exp_chain = '0;
    push_word(w0, 8);
    push_word(w1, 4);
    s.start = 1'b1;
    tick();
    s.start = poke;
    chk("busy_wait", 32'(s.busy), 1);
    chk("bits_loaded", 32'(s.bits_remaining), 12);
    chk("ready_wait", 32'(s.word_ready), 1);
    s.word_valid = 1'b1;
    s.word_data  = w0;
    wait_hs();
    s.word_data = w1;
    if (stall) begin
      s.word_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (s.word_ready) break;
        tick();
      end
      for (int i = 0; i < 5; i++) begin
        tick();
        chk("stall_ready", 32'(s.word_ready), 1);
        chk("stall_no_shift", 32'(s.chain_shift_enable), 0);
        chk("stall_bits_hold", 32'(s.bits_remaining), 4);
      end
      s.word_valid = 1'b1;
    end
    wait_hs();
    s.word_valid = 1'b0;
    s.start      = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (s.done) break;
      tick();
    end
    chk("done_seen", 32'(s.done), 1);
    chk("busy_at_done", 32'(s.busy), 0);
    chk("done_latency", 32'(cyc - last_shift_cyc), 1);
    chk("shift_count", 32'(shifts), 12);
    chk("handshakes", 32'(hs), 2);
    chk("chain", 32'(chain), 32'(exp_chain));
    chk("sb_empty", 32'(q.size()), 0);
    tick();
    chk("done_one_cycle", 32'(s.done), 0);
    chk("bits_idle", 32'(s.bits_remaining), 0);
    chk("done_count", 32'(dones), 1);
  endtask

  initial begin
    rst = 1'b1;
    s.start = 1'b0; s.abort = 1'b0; s.word_valid = 1'b0; s.word_data = '0;
    t.start = 1'b0; t.abort = 1'b0; t.word_valid = 1'b0; t.word_data = '0;
    cyc = 0; last_shift_cyc = 0; shifts = 0; hs = 0; dones = 0; last_hs = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(s.word_ready), 0);
    chk("rst_en", 32'(s.chain_shift_enable), 0);
    chk("rst_in", 32'(s.chain_shift_in), 0);
    chk("rst_busy", 32'(s.busy), 0);
    chk("rst_done", 32'(s.done), 0);
    chk("rst_bits", 32'(s.bits_remaining), 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(s.busy), 0);

    // Basic load, valid held high
    load12(8'hA5, 8'h03, 1'b0, 1'b0);
    chk("chain_pattern", 32'(chain), 32'h0A5C);

    // Stall before second word
    chain = '0;
    load12(8'hA5, 8'h03, 1'b1, 1'b0);
    chk("chain_pattern_stall", 32'(chain), 32'h0A5C);

    // Abort on the third shift of the first word
    q.delete(); shifts = 0; dones = 0;
    push_word(8'hFF, 3);
    s.start = 1'b1;
    tick();
    s.start = 1'b0;
    s.word_valid = 1'b1;
    s.word_data  = 8'hFF;
    wait_hs();
    s.word_valid = 1'b0;
    tick();
    tick();
    s.abort = 1'b1;
    tick();
    s.abort = 1'b0;
    chk("abort_shifts", 32'(shifts), 3);
    chk("abort_busy", 32'(s.busy), 0);
    chk("abort_bits", 32'(s.bits_remaining), 0);
    chk("abort_en", 32'(s.chain_shift_enable), 0);
    chk("abort_ready", 32'(s.word_ready), 0);
    tick();
    chk("abort_no_done", 32'(dones), 0);
    chk("abort_idle", 32'(s.busy), 0);

    // Reset during SHIFT
    q.delete();
    push_word(8'hA5, 8);
    s.start = 1'b1;
    tick();
    s.start = 1'b0;
    s.word_valid = 1'b1;
    s.word_data  = 8'hA5;
    wait_hs();
    s.word_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    chk("mrst_ready", 32'(s.word_ready), 0);
    chk("mrst_en", 32'(s.chain_shift_enable), 0);
    chk("mrst_in", 32'(s.chain_shift_in), 0);
    chk("mrst_busy", 32'(s.busy), 0);
    chk("mrst_done", 32'(s.done), 0);
    chk("mrst_bits", 32'(s.bits_remaining), 0);
    load12(8'h3C, 8'h0A, 1'b0, 1'b0);

    // start held high throughout the load is ignored
    load12(8'h5A, 8'h0F, 1'b1, 1'b1);

    // Single-bit chain
    t.start = 1'b1;
    tick();
    t.start = 1'b0;
    chk("c1_ready", 32'(t.word_ready), 1);
    t.word_valid = 1'b1;
    t.word_data  = 8'hFE;
    tick();
    t.word_valid = 1'b0;
    chk("c1_en", 32'(t.chain_shift_enable), 1);
    chk("c1_in", 32'(t.chain_shift_in), 0);
    tick();
    chk("c1_done", 32'(t.done), 1);
    chk("c1_busy", 32'(t.busy), 0);
    chk("c1_en_off", 32'(t.chain_shift_enable), 0);
    tick();
    chk("c1_done_off", 32'(t.done), 0);
    chk("c1_bits", 32'(t.bits_remaining), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
